regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the single-write, two-read datapath register file.
- Configurable width, depth and read-port count; optional hardwired-zero register 0; optional write-to-read bypass.
- Hardware sequential clear engine zeroes the array after reset or on request, so a large array needs no async reset.
- Sits in the decode stage, feeding ALU operand muxes; the writeback stage drives the write port.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_clear_ctrl.sv | 70 +++++++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file and the decode stage
// that instantiates it: clear-engine state encoding and the default
// width/depth/address constants.
// -----------------------------------------------------------------------------
package regfile_pkg;

  // Clear engine states. S_CLEAR is the reset state; BUSY is high in S_CLEAR.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam int DEF_REGISTER_WIDTH = 32;
  localparam int DEF_REGISTER_DEPTH = 32;
  localparam int DEF_ADDRESS_WIDTH  = 5;
  localparam int DEF_NUM_READ       = 2;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_clear_ctrl
// Sequential clear engine for regfile_mp. After reset, or whenever i_clr is
// seen, it walks an index from 0 to REGISTER_DEPTH-1, one entry per clock,
// and strobes a zero write into the array. o_busy is high for the whole walk.
//
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-high reset (restarts the walk)
//   i_clr       synchronous clear request (restarts the walk at index 0)
//   o_busy      high while the walk is in progress
//   o_clr_we    clear-write strobe for the array
//   o_clr_addr  array index to be zeroed when o_clr_we is high
// -----------------------------------------------------------------------------
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int REGISTER_DEPTH = DEF_REGISTER_DEPTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic                     o_clr_we,
  output logic [ADDRESS_WIDTH-1:0] o_clr_addr
);

  // One extra bit so a depth of 2**ADDRESS_WIDTH never wraps the counter
  // before the terminal compare.
  localparam logic [ADDRESS_WIDTH:0] LAST_IDX = (ADDRESS_WIDTH+1)'(REGISTER_DEPTH - 1);

  state_t                 r_state;
  logic [ADDRESS_WIDTH:0] r_idx;
  logic                   r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else if (i_clr) begin
      // A request in either state restarts the walk from the bottom.
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = (r_state == S_CLEAR);
  // The written index never exceeds REGISTER_DEPTH-1, so the top bit is only
  // needed for the terminal compare.
  assign o_clr_addr = r_idx[ADDRESS_WIDTH-1:0];

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file for the decode stage: one write port driven by
// writeback, NUM_READ combinational read ports feeding the ALU operand muxes.
// Optional hardwired-zero register 0 and optional write-to-read bypass. The
// array has no reset; regfile_clear_ctrl zeroes it after reset or on CLR, and
// all reads return 0 while that walk is running.
//
// Ports:
//   CLK      clock
//   RST      asynchronous active-high reset
//   CLR      synchronous clear request (pulse or level)
//   WE3      write enable
//   A3       write address
//   WD3      write data
//   RA       packed read addresses, port k at [k*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   RD       packed read data, port k at [k*REGISTER_WIDTH +: REGISTER_WIDTH]
//   BUSY     high while the clear engine runs
//   WR_DROP  one-cycle pulse: the previous cycle's write was rejected
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int REGISTER_DEPTH = DEF_REGISTER_DEPTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int NUM_READ       = DEF_NUM_READ,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               CLR,
  input  logic                               WE3,
  input  logic [ADDRESS_WIDTH-1:0]           A3,
  input  logic [REGISTER_WIDTH-1:0]          WD3,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  RA,
  output logic [NUM_READ*REGISTER_WIDTH-1:0] RD,
  output logic                               BUSY,
  output logic                               WR_DROP
);

  localparam int IDX_W = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(REGISTER_DEPTH);

  logic [REGISTER_WIDTH-1:0] r_mem [REGISTER_DEPTH];
  logic                      r_wr_drop;

  logic                      w_busy;
  logic                      w_clr_we;
  logic [ADDRESS_WIDTH-1:0]  w_clr_addr;
  logic                      w_a3_in_range;
  logic                      w_a3_is_zero;
  logic                      w_wr_ok;
  logic [ADDRESS_WIDTH-1:0]  w_ra;

  regfile_clear_ctrl #(
    .REGISTER_DEPTH (REGISTER_DEPTH),
    .ADDRESS_WIDTH  (ADDRESS_WIDTH)
  ) u_clear_ctrl (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr      (CLR),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Write acceptance. CLR in the same cycle wins over the write.
  assign w_a3_in_range = ({1'b0, A3} < DEPTH_L);
  assign w_a3_is_zero  = (ZERO_REG != 0) && (A3 == '0);
  assign w_wr_ok       = WE3 && !w_busy && !CLR && w_a3_in_range && !w_a3_is_zero;

  // Array has no reset; the clear engine owns it while busy.
  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[A3[IDX_W-1:0]] <= WD3;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= WE3 && !w_wr_ok;
    end
  end

  // Read ports: gated to zero while clearing, for out-of-range addresses and
  // for the hardwired zero register; bypass forwards an accepted write.
  always_comb begin
    RD   = '0;
    w_ra = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      w_ra = RA[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (!w_busy && ({1'b0, w_ra} < DEPTH_L) && !((ZERO_REG != 0) && (w_ra == '0))) begin
        if ((BYPASS != 0) && w_wr_ok && (A3 == w_ra)) begin
          RD[k*REGISTER_WIDTH +: REGISTER_WIDTH] = WD3;
        end else begin
          RD[k*REGISTER_WIDTH +: REGISTER_WIDTH] = r_mem[w_ra[IDX_W-1:0]];
        end
      end
    end
  end

  assign BUSY    = w_busy;
  assign WR_DROP = r_wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp. Instance dut: depth 32, four read ports.
// Instance dut_b: depth 20, two read ports, for the out-of-range cases.
// Inputs change 1 time unit after posedge; outputs are sampled 3 after.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int NR  = 4;
  localparam int NRB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clr, we3, busy, wr_drop;
  logic [AW-1:0]    a3;
  logic [W-1:0]     wd3;
  logic [NR*AW-1:0] ra;
  logic [NR*W-1:0]  rd;

  logic              b_clr, b_we3, b_busy, b_wr_drop;
  logic [AW-1:0]     b_a3;
  logic [W-1:0]      b_wd3;
  logic [NRB*AW-1:0] b_ra;
  logic [NRB*W-1:0]  b_rd;

  regfile_mp #(.REGISTER_WIDTH(W), .REGISTER_DEPTH(32), .ADDRESS_WIDTH(AW),
               .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(clk), .RST(rst), .CLR(clr), .WE3(we3), .A3(a3), .WD3(wd3),
    .RA(ra), .RD(rd), .BUSY(busy), .WR_DROP(wr_drop));

  regfile_mp #(.REGISTER_WIDTH(W), .REGISTER_DEPTH(20), .ADDRESS_WIDTH(AW),
               .NUM_READ(NRB), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .CLK(clk), .RST(rst), .CLR(b_clr), .WE3(b_we3), .A3(b_a3), .WD3(b_wd3),
    .RA(b_ra), .RD(b_rd), .BUSY(b_busy), .WR_DROP(b_wr_drop));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  function automatic logic [W-1:0] rdp(input int k);
    return rd[k*W +: W];
  endfunction

  function automatic logic [W-1:0] rdb(input int k);
    return b_rd[k*W +: W];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point; counts busy samples, one per clock, bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      next_cyc();
      #2;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    next_cyc();
    we3 = 1'b1; a3 = a; wd3 = d;
    next_cyc();
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    int n, bad;
    rst = 1'b1; clr = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0;
    b_clr = 1'b0; b_we3 = 1'b0; b_a3 = '0; b_wd3 = '0;
    for (int k = 0; k < NR; k++) set_ra(k, 5'd5);
    b_ra = {5'd5, 5'd5};
    repeat (3) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd); end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    n = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      if (rd !== '0) bad++;
      next_cyc(); #2;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL reset_busy_len: got %0d want 32", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_rd_during_clear: got %0d nonzero want 0", bad); end
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL reset_read5: got %h want %h", rdp(0), exp_v); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
  endtask

  task automatic test_basic_write();
    next_cyc();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
    set_ra(0, 5'd7); set_ra(1, 5'd7); set_ra(2, 5'd8);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF); exp_q.push_back('0);
    #2;
    for (int k = 0; k < 3; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL basic_bypass_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
    next_cyc();
    we3 = 1'b0;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    #2;
    for (int k = 0; k < 2; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL basic_stored_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL basic_wr_drop: got %b want 0", wr_drop); end
  endtask

  task automatic test_zero_reg();
    next_cyc();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234; set_ra(0, 5'd0);
    exp_q.push_back('0);
    #2;
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL zero_bypass: got %h want %h", rdp(0), exp_v); end
    next_cyc();
    we3 = 1'b0;
    exp_q.push_back('0);
    #2;
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL zero_wr_drop: got %b want 1", wr_drop); end
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL zero_read: got %h want %h", rdp(0), exp_v); end
    next_cyc(); #2;
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL zero_wr_drop_pulse: got %b want 0", wr_drop); end
  endtask

  task automatic test_out_of_range();
    next_cyc();
    b_we3 = 1'b1; b_a3 = 5'd25; b_wd3 = 32'hCAFE; b_ra = {5'd19, 5'd25};
    exp_q.push_back('0);
    #2;
    exp_v = exp_q.pop_front();
    checks++; if (rdb(0) !== exp_v) begin errors++; $display("FAIL oor_bypass: got %h want %h", rdb(0), exp_v); end
    next_cyc();
    b_we3 = 1'b0;
    exp_q.push_back('0);
    #2;
    checks++; if (b_wr_drop !== 1'b1) begin errors++; $display("FAIL oor_wr_drop: got %b want 1", b_wr_drop); end
    exp_v = exp_q.pop_front();
    checks++; if (rdb(0) !== exp_v) begin errors++; $display("FAIL oor_read: got %h want %h", rdb(0), exp_v); end
    // Highest legal address of the 20-deep instance must still be writable.
    next_cyc();
    b_we3 = 1'b1; b_a3 = 5'd19; b_wd3 = 32'h77;
    exp_q.push_back(32'h77);
    next_cyc();
    b_we3 = 1'b0;
    #2;
    checks++; if (b_wr_drop !== 1'b0) begin errors++; $display("FAIL top_wr_drop: got %b want 0", b_wr_drop); end
    exp_v = exp_q.pop_front();
    checks++; if (rdb(1) !== exp_v) begin errors++; $display("FAIL top_read19: got %h want %h", rdb(1), exp_v); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NR; k++) begin
      next_cyc();
      we3 = 1'b1; a3 = 5'(10 + k); wd3 = 32'hA000_0000 + 32'(k * 3 + 1);
      exp_q.push_back(32'hA000_0000 + 32'(k * 3 + 1));
    end
    next_cyc();
    we3 = 1'b0;
    for (int k = 0; k < NR; k++) set_ra(k, 5'(10 + k));
    #2;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL b2b_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL b2b_wr_drop: got %b want 0", wr_drop); end
  endtask

  task automatic test_clr_collision();
    int n;
    wr(5'd3, 32'h11);
    set_ra(0, 5'd3); set_ra(1, 5'd7);
    exp_q.push_back(32'h11);
    #2;
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL clr_pre_read: got %h want %h", rdp(0), exp_v); end
    next_cyc();
    clr = 1'b1; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hAA;
    next_cyc();
    clr = 1'b0; we3 = 1'b0;
    #2;
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL clr_wr_drop: got %b want 1", wr_drop); end
    count_busy(n);
    checks++; if (n != 32) begin errors++; $display("FAIL clr_busy_len: got %0d want 32", n); end
    exp_q.push_back('0); exp_q.push_back('0);
    for (int k = 0; k < 2; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL clr_read_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
  endtask

  task automatic test_write_during_busy();
    int n;
    wr(5'd9, 32'h99);
    set_ra(0, 5'd9);
    exp_q.push_back(32'h99);
    #2;
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL busy_pre_read: got %h want %h", rdp(0), exp_v); end
    next_cyc(); clr = 1'b1;
    next_cyc(); clr = 1'b0;
    repeat (9) next_cyc();
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55;
    exp_q.push_back('0);
    #2;
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL busy_gated_read: got %h want %h", rdp(0), exp_v); end
    next_cyc();
    we3 = 1'b0;
    #2;
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL busy_wr_drop: got %b want 1", wr_drop); end
    count_busy(n);
    checks++; if (n != 22) begin errors++; $display("FAIL busy_remaining: got %0d want 22", n); end
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    checks++; if (rdp(0) !== exp_v) begin errors++; $display("FAIL busy_read9: got %h want %h", rdp(0), exp_v); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [AW-1:0] addrs [NR];
    addrs = '{5'd1, 5'd2, 5'd30, 5'd31};
    for (int k = 0; k < NR; k++) begin
      wr(addrs[k], 32'h5000 + 32'(k));
      exp_q.push_back(32'h5000 + 32'(k));
    end
    for (int k = 0; k < NR; k++) set_ra(k, addrs[k]);
    #2;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL rmc_pre_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
    next_cyc(); clr = 1'b1;
    next_cyc(); clr = 1'b0;
    repeat (14) next_cyc();
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_in_reset: got %b want 1", busy); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL rmc_rd_in_reset: got %h want 0", rd); end
    repeat (2) next_cyc();
    rst = 1'b0;
    #2;
    count_busy(n);
    checks++; if (n != 32) begin errors++; $display("FAIL rmc_busy_len: got %0d want 32", n); end
    for (int k = 0; k < NR; k++) exp_q.push_back('0);
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rdp(k) !== exp_v) begin errors++; $display("FAIL rmc_read_p%0d: got %h want %h", k, rdp(k), exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_out_of_range();
    test_back_to_back();
    test_clr_collision();
    test_write_during_busy();
    test_reset_mid_clear();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
